// File: rtl/ad5676_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ad5676_pkg
// Description : Shared constants for the AD5676 SPI back end: DAC command
//               codes, frame width and the shifter state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package ad5676_pkg;

    // AD5676 command nibbles (frame bits [23:20])
    localparam logic [3:0] CMD_WR_INPUT  = 4'h1;
    localparam logic [3:0] CMD_UPDATE    = 4'h2;
    localparam logic [3:0] CMD_WR_UPDATE = 4'h3;
    localparam logic [3:0] CMD_READBACK  = 4'h9;

    localparam int FRAME_BITS = 24;

    // Shifter state encoding
    localparam int         STATE_W  = 3;
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;

endpackage
`default_nettype wire

// File: rtl/ad5676_sck_gen.sv
`default_nettype none
// ============================================================================
// Module      : ad5676_sck_gen
// Description : Half-period timer for the SPI clock. While enabled it emits
//               one strobe every HALF_PERIOD clk cycles; the strobe is
//               reported as sck_fall when sck is currently high and as
//               sck_rise when sck is currently low.
// Ports       : clk, resetn    - clock, async active-low reset
//               en             - count enable (shifter is in SHIFT)
//               sck            - current registered sck level
//               sck_rise/fall  - single-cycle strobes, next edge flips sck
// Revision    : 1.0 - initial release
// ============================================================================
module ad5676_sck_gen #(
    parameter int HALF_PERIOD = 1
) (
    input  logic clk,
    input  logic resetn,
    input  logic en,
    input  logic sck,
    output logic sck_rise,
    output logic sck_fall
);

    localparam logic [3:0] C_RELOAD = 4'(HALF_PERIOD - 1);

    logic [3:0] r_cnt;
    logic       w_tick;

    // Held at the reload value while disabled, so the first half-period
    // after entering SHIFT is always full length.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= C_RELOAD;
        end else if (!en || (r_cnt == 4'd0)) begin
            r_cnt <= C_RELOAD;
        end else begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    assign w_tick   = en && (r_cnt == 4'd0);
    assign sck_rise = w_tick && !sck;
    assign sck_fall = w_tick && sck;

endmodule
`default_nettype wire

// File: rtl/ad5676_spi_shifter.sv
`default_nettype none
// ============================================================================
// Module      : ad5676_spi_shifter
// Description : SPI serializer for one AD5676 octal DAC. Takes 24-bit frames
//               over valid/ready, shifts them MSB-first on n_cs/sck/mosi and
//               captures 24 bits of readback from miso.
// Ports       : clk, resetn          - clock, async active-low reset
//               frame_valid/ready    - upstream frame handshake
//               frame_data[23:0]     - {cmd[3:0], addr[3:0], data[15:0]}
//               abort                - terminate current frame
//               busy                 - not in IDLE
//               frame_done, rd_valid - one-cycle completion pulses
//               aborted              - sticky, set by a mid-frame abort
//               rd_data[23:0]        - readback of last completed frame
//               n_cs, sck, mosi      - SPI outputs (registered)
//               miso                 - SPI input (used unsynchronized)
// Revision    : 1.0 - initial release
// ============================================================================
module ad5676_spi_shifter
    import ad5676_pkg::*;
#(
    parameter int HALF_PERIOD = 1,
    parameter int CS_SETUP    = 1,
    parameter int CS_HOLD     = 1,
    parameter int CS_HIGH_MIN = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  frame_valid,
    input  logic [FRAME_BITS-1:0] frame_data,
    output logic                  frame_ready,
    input  logic                  abort,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  aborted,
    output logic [FRAME_BITS-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  n_cs,
    output logic                  sck,
    output logic                  mosi,
    input  logic                  miso
);

    localparam logic [3:0] C_SETUP_RELOAD = 4'(CS_SETUP - 1);
    localparam logic [3:0] C_HOLD_RELOAD  = 4'(CS_HOLD - 1);
    localparam logic [3:0] C_GAP_RELOAD   = 4'(CS_HIGH_MIN - 1);
    localparam logic [4:0] C_LAST_BIT     = 5'(FRAME_BITS - 1);

    logic [STATE_W-1:0]    r_state;
    logic [3:0]            r_cnt;
    logic [4:0]            r_bit_idx;
    logic [FRAME_BITS-1:0] r_sr;
    logic [FRAME_BITS-1:0] r_shadow;
    logic [FRAME_BITS-1:0] r_rd_data;
    logic                  r_n_cs;
    logic                  r_sck;
    logic                  r_mosi;
    logic                  r_done;
    logic                  r_rd_valid;
    logic                  r_aborted;

    logic w_ready;
    logic w_accept;
    logic w_sck_rise;
    logic w_sck_fall;
    logic w_in_frame;

    // Gated by resetn so ready reads low while reset is held and high
    // immediately after release.
    assign w_ready    = resetn && (r_state == ST_IDLE) && !abort;
    assign w_accept   = frame_valid && w_ready;
    assign w_in_frame = (r_state == ST_SETUP) || (r_state == ST_SHIFT) ||
                        (r_state == ST_HOLD);

    ad5676_sck_gen #(
        .HALF_PERIOD (HALF_PERIOD)
    ) u_sck_gen (
        .clk      (clk),
        .resetn   (resetn),
        .en       (r_state == ST_SHIFT),
        .sck      (r_sck),
        .sck_rise (w_sck_rise),
        .sck_fall (w_sck_fall)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 4'd0;
            r_bit_idx  <= 5'd0;
            r_sr       <= '0;
            r_shadow   <= '0;
            r_rd_data  <= '0;
            r_n_cs     <= 1'b1;
            r_sck      <= 1'b0;
            r_mosi     <= 1'b0;
            r_done     <= 1'b0;
            r_rd_valid <= 1'b0;
            r_aborted  <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_rd_valid <= 1'b0;

            if (abort && (r_state != ST_IDLE)) begin
                r_n_cs  <= 1'b1;
                r_sck   <= 1'b0;
                r_mosi  <= 1'b0;
                r_state <= ST_GAP;
                r_cnt   <= C_GAP_RELOAD;
                if (w_in_frame) begin
                    r_aborted <= 1'b1;
                end
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_accept) begin
                            r_sr    <= frame_data;
                            r_n_cs  <= 1'b0;
                            r_cnt   <= C_SETUP_RELOAD;
                            r_state <= ST_SETUP;
                        end
                    end

                    // The SETUP exit edge is also the first sck rising edge.
                    ST_SETUP: begin
                        if (r_cnt == 4'd0) begin
                            r_state   <= ST_SHIFT;
                            r_sck     <= 1'b1;
                            r_mosi    <= r_sr[FRAME_BITS-1];
                            r_sr      <= {r_sr[FRAME_BITS-2:0], 1'b0};
                            r_bit_idx <= C_LAST_BIT;
                        end else begin
                            r_cnt <= r_cnt - 4'd1;
                        end
                    end

                    // r_bit_idx counts bits still to send; a rise strobe with
                    // nothing left marks the end of the final low half-period.
                    ST_SHIFT: begin
                        if (w_sck_fall) begin
                            r_sck    <= 1'b0;
                            r_shadow <= {r_shadow[FRAME_BITS-2:0], miso};
                        end else if (w_sck_rise) begin
                            if (r_bit_idx == 5'd0) begin
                                r_state <= ST_HOLD;
                                r_cnt   <= C_HOLD_RELOAD;
                            end else begin
                                r_sck     <= 1'b1;
                                r_mosi    <= r_sr[FRAME_BITS-1];
                                r_sr      <= {r_sr[FRAME_BITS-2:0], 1'b0};
                                r_bit_idx <= r_bit_idx - 5'd1;
                            end
                        end
                    end

                    ST_HOLD: begin
                        if (r_cnt == 4'd0) begin
                            r_n_cs     <= 1'b1;
                            r_mosi     <= 1'b0;
                            r_rd_data  <= r_shadow;
                            r_done     <= 1'b1;
                            r_rd_valid <= 1'b1;
                            r_state    <= ST_GAP;
                            r_cnt      <= C_GAP_RELOAD;
                        end else begin
                            r_cnt <= r_cnt - 4'd1;
                        end
                    end

                    ST_GAP: begin
                        if (r_cnt == 4'd0) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_cnt <= r_cnt - 4'd1;
                        end
                    end

                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign frame_ready = w_ready;
    assign busy        = (r_state != ST_IDLE);
    assign frame_done  = r_done;
    assign rd_valid    = r_rd_valid;
    assign rd_data     = r_rd_data;
    assign aborted     = r_aborted;
    assign n_cs        = r_n_cs;
    assign sck         = r_sck;
    assign mosi        = r_mosi;

endmodule
`default_nettype wire

// File: tb/tb_ad5676_spi_shifter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ad5676_spi_shifter
// Description : Scoreboard bench for ad5676_spi_shifter. One instance uses
//               default timing, a second uses HALF_PERIOD=2 for readback.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ad5676_spi_shifter;

    typedef struct {
        logic [23:0] mosi;
        logic [23:0] rd;
        int          done_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;

    // default-timing instance
    logic        frame_valid, abort, miso;
    logic [23:0] frame_data;
    logic        frame_ready, busy, frame_done, aborted, rd_valid;
    logic [23:0] rd_data;
    logic        n_cs, sck, mosi;

    // HALF_PERIOD=2 instance
    logic        frame_valid2, abort2, miso2;
    logic [23:0] frame_data2;
    logic        frame_ready2, busy2, frame_done2, aborted2, rd_valid2;
    logic [23:0] rd_data2;
    logic        n_cs2, sck2, mosi2;

    exp_t        exp_q[$];
    exp_t        exp2_q[$];
    logic [23:0] rb_pat, rb_pat2;
    int          rb_idx, rb_idx2;

    // monitor state for the default instance
    logic        prev_sck, prev_ncs;
    int          rise_cnt, fall_cnt, cs_high_run, cs_high_last;
    logic [23:0] mosi_cap;

    ad5676_spi_shifter dut (
        .clk (clk), .resetn (resetn),
        .frame_valid (frame_valid), .frame_data (frame_data), .frame_ready (frame_ready),
        .abort (abort), .busy (busy), .frame_done (frame_done), .aborted (aborted),
        .rd_data (rd_data), .rd_valid (rd_valid),
        .n_cs (n_cs), .sck (sck), .mosi (mosi), .miso (miso)
    );

    ad5676_spi_shifter #(.HALF_PERIOD (2)) dut2 (
        .clk (clk), .resetn (resetn),
        .frame_valid (frame_valid2), .frame_data (frame_data2), .frame_ready (frame_ready2),
        .abort (abort2), .busy (busy2), .frame_done (frame_done2), .aborted (aborted2),
        .rd_data (rd_data2), .rd_valid (rd_valid2),
        .n_cs (n_cs2), .sck (sck2), .mosi (mosi2), .miso (miso2)
    );

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // DAC readback models: next bit presented on each sck rising edge
    initial begin miso = 1'b0; forever begin @(negedge n_cs); rb_idx = 23; end end
    initial forever begin
        @(posedge sck);
        if (rb_idx >= 0) begin miso = rb_pat[rb_idx]; rb_idx--; end
    end
    initial begin miso2 = 1'b0; forever begin @(negedge n_cs2); rb_idx2 = 23; end end
    initial forever begin
        @(posedge sck2);
        if (rb_idx2 >= 0) begin miso2 = rb_pat2[rb_idx2]; rb_idx2--; end
    end

    // Monitor for the default instance: DAC-side view of mosi and completion
    initial begin
        exp_t e;
        prev_sck = 1'b0; prev_ncs = 1'b1; rise_cnt = 0; fall_cnt = 0;
        cs_high_run = 0; cs_high_last = 0; mosi_cap = '0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                prev_sck = 1'b0; prev_ncs = 1'b1; rise_cnt = 0; fall_cnt = 0; mosi_cap = '0;
            end else begin
                if (n_cs) begin
                    cs_high_run++;
                end else begin
                    if (prev_ncs) begin
                        cs_high_last = cs_high_run;
                        rise_cnt = 0; fall_cnt = 0; mosi_cap = '0;
                    end
                    cs_high_run = 0;
                end
                if (!prev_sck && sck) rise_cnt++;
                if (prev_sck && !sck && !n_cs) begin
                    fall_cnt++;
                    mosi_cap = {mosi_cap[22:0], mosi};
                end
                if (frame_done || rd_valid) begin
                    chk("done/rd_valid coincide", 32'(frame_done), 32'(rd_valid));
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected frame_done at cyc %0d, rd_data 0x%0h", cyc, rd_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("mosi frame", 32'(mosi_cap), 32'(e.mosi));
                        chk("sck pulse count", 32'(fall_cnt), 32'd24);
                        chk("rd_data", 32'(rd_data), 32'(e.rd));
                        chk("done cycle", 32'(cyc), 32'(e.done_cyc));
                    end
                end
                prev_sck = sck;
                prev_ncs = n_cs;
            end
        end
    end

    // Monitor for the HALF_PERIOD=2 instance
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (resetn && (frame_done2 || rd_valid2)) begin
                chk("hp2 done/rd_valid coincide", 32'(frame_done2), 32'(rd_valid2));
                if (exp2_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL hp2 unexpected frame_done at cyc %0d", cyc);
                end else begin
                    e = exp2_q.pop_front();
                    chk("hp2 rd_data", 32'(rd_data2), 32'(e.rd));
                    chk("hp2 done cycle", 32'(cyc), 32'(e.done_cyc));
                end
            end
        end
    end

    // Call at a negedge. Frame length with defaults is 50 cycles from the
    // accept edge, so done is seen at the negedge with cyc = accept-sample + 51.
    task automatic send(input logic [23:0] d, input logic [23:0] rb, output int acc);
        exp_t e;
        acc = -1;
        frame_data  = d;
        frame_valid = 1'b1;
        for (int i = 0; i < 200 && acc < 0; i++) begin
            if (frame_ready) begin
                acc = cyc;
                rb_pat = rb;
                e.mosi = d; e.rd = rb; e.done_cyc = cyc + 51;
                exp_q.push_back(e);
                @(posedge clk);
                #1;
                chk("n_cs low after accept", 32'(n_cs), 32'd0);
            end else begin
                @(negedge clk);
            end
        end
        if (acc < 0) begin
            checks++; errors++;
            $display("FAIL accept timeout: frame 0x%0h not accepted", d);
        end
        @(negedge clk);
        frame_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) ok = 1'b1;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL %s: timeout waiting for idle, pending=%0d", name, exp_q.size());
        end
    endtask

    initial begin
        int   acc1, acc2, m;
        bit   hit;
        exp_t e2;
        resetn = 1'b1;
        frame_valid = 1'b0; frame_data = '0; abort = 1'b0;
        frame_valid2 = 1'b0; frame_data2 = '0; abort2 = 1'b0;
        rb_pat = '0; rb_pat2 = '0;
        #2 resetn = 1'b0;
        repeat (3) @(negedge clk);

        // reset state
        chk("reset pins/flags {n_cs,sck,mosi,ready,busy,done,aborted,rd_valid}",
            32'({n_cs, sck, mosi, frame_ready, busy, frame_done, aborted, rd_valid}), 32'h80);
        chk("reset rd_data", 32'(rd_data), 32'd0);
        resetn = 1'b1;
        #1 chk("ready after reset release", 32'(frame_ready), 32'd1);

        // single frame, defaults
        @(negedge clk);
        send(24'h328000, 24'h123456, acc1);
        wait_idle("single frame");

        // back-to-back frames with valid held
        @(negedge clk);
        send(24'h15ABCD, 24'hFEDCBA, acc1);
        send(24'h970000, 24'h0F0F0F, acc2);
        #1;
        chk("accept-to-accept spacing", 32'(acc2 - acc1), 32'd53);
        chk("n_cs high >= 2 between frames", 32'(cs_high_last >= 2), 32'd1);
        wait_idle("back-to-back");

        // abort at the 10th sck rising edge
        @(negedge clk);
        send(24'h30FFFF, 24'h000000, acc1);
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk); #1;
            if (rise_cnt == 10) hit = 1'b1;
        end
        chk("reached 10th sck rise", 32'(hit), 32'd1);
        abort = 1'b1;
        m = cyc;
        exp_q.delete();
        @(posedge clk); #1;
        chk("abort pins {n_cs,sck,mosi}", 32'({n_cs, sck, mosi}), 32'h4);
        chk("aborted set", 32'(aborted), 32'd1);
        chk("busy in gap after abort", 32'(busy), 32'd1);
        @(negedge clk);
        abort = 1'b0;
        send(24'h211234, 24'h800001, acc2);
        chk("accept after abort gap", 32'(acc2 - m), 32'd3);
        wait_idle("after abort");
        chk("aborted sticky", 32'(aborted), 32'd1);

        // asynchronous reset mid-SHIFT
        @(negedge clk);
        send(24'h1300FF, 24'h000000, acc1);
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk); #1;
            if (rise_cnt >= 5) hit = 1'b1;
        end
        #2 resetn = 1'b0;
        exp_q.delete();
        #1;
        chk("async reset n_cs", 32'(n_cs), 32'd1);
        chk("async reset outputs {sck,mosi,ready,busy,done,aborted,rd_valid}",
            32'({sck, mosi, frame_ready, busy, frame_done, aborted, rd_valid}), 32'h0);
        chk("async reset rd_data", 32'(rd_data), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        #1 chk("ready first cycle after release", 32'(frame_ready), 32'd1);

        // abort together with frame_valid in IDLE
        @(negedge clk);
        frame_data = 24'h3F1111; frame_valid = 1'b1; abort = 1'b1;
        #1 chk("ready forced low by idle abort", 32'(frame_ready), 32'd0);
        @(posedge clk); #1;
        chk("no accept on idle abort {busy,n_cs}", 32'({busy, n_cs}), 32'h1);
        chk("aborted stays clear", 32'(aborted), 32'd0);
        @(negedge clk);
        frame_valid = 1'b0; abort = 1'b0;

        // readback with HALF_PERIOD=2: 1 + 96 + 1 = 98 cycles of frame
        @(negedge clk);
        rb_pat2 = 24'hA5C3F0;
        frame_data2 = 24'h900000; frame_valid2 = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 50 && !hit; i++) begin
            if (frame_ready2) begin
                hit = 1'b1;
                e2.mosi = 24'h900000; e2.rd = 24'hA5C3F0; e2.done_cyc = cyc + 99;
                exp2_q.push_back(e2);
            end
            @(negedge clk);
        end
        frame_valid2 = 1'b0;
        chk("hp2 frame accepted", 32'(hit), 32'd1);
        hit = 1'b0;
        for (int i = 0; i < 300 && !hit; i++) begin
            @(negedge clk);
            if (!busy2 && exp2_q.size() == 0) hit = 1'b1;
        end
        chk("hp2 frame completed", 32'(hit), 32'd1);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/ad5676_spi_shifter.md
# ad5676_spi_shifter

Serial back end for one AD5676 octal DAC. Accepts 24-bit DAC frames (4-bit command, 4-bit address, 16-bit offset-binary data) from the DAC sequencing controller over a valid/ready handshake. Serializes each frame MSB-first on n_cs/sck/mosi and optionally captures a 24-bit readback from miso. Sits between the DAC controller and the board pins; it owns all SPI pin timing.

## Interface
- HALF_PERIOD, 1: clk cycles per sck half-period, range 1–15.
- CS_SETUP, 1: clk cycles from n_cs falling to the first sck rising edge, range 1–15.
- CS_HOLD, 1: clk cycles from the last sck falling edge to n_cs rising, range 1–15.
- CS_HIGH_MIN, 2: minimum clk cycles n_cs stays high between frames, range 1–15.
- clk  in  1  system clock.
- resetn  in  1  active-low reset; one clock; reset is asynchronous and active-low.
- frame_valid  in  1  upstream has a frame.
- frame_data  in  24  frame; bits [23:20] command, [19:16] address, [15:0] data.
- frame_ready  out  1  shifter accepts a frame this cycle.
- abort  in  1  terminate the current frame immediately.
- busy  out  1  a frame is in progress (any state except IDLE).
- frame_done  out  1  one-cycle pulse when a frame completes normally.
- aborted  out  1  sticky flag, set by an abort taken mid-frame; cleared only by reset.
- rd_data  out  24  bits captured from miso during the last completed frame.
- rd_valid  out  1  one-cycle pulse coincident with frame_done.
- n_cs  out  1  DAC chip select, active low.
- sck  out  1  SPI clock; idles low.
- mosi  out  1  serial data to the DAC.
- miso  in  1  serial data from the DAC.

## Operation
- Reset values: n_cs=1, sck=0, mosi=0, frame_ready=0, busy=0, frame_done=0, aborted=0, rd_data=0, rd_valid=0, state=IDLE. n_cs goes high asynchronously the moment resetn asserts, including mid-frame.
- States: IDLE, SETUP, SHIFT, HOLD, GAP.
- IDLE: frame_ready=1. When frame_valid&frame_ready, latch frame_data into the shift register, drive n_cs=0, load the counter with CS_SETUP-1, and go to SETUP.
- SETUP: count down. At 0, go to SHIFT with bit index 23.
- SHIFT: on each sck rising edge, mosi takes shift-register bit [23] and the register shifts left. sck is held high for HALF_PERIOD cycles, then low for HALF_PERIOD cycles. The DAC samples mosi on the falling edge.
  - miso is sampled in the clk cycle that drives sck from 1 to 0 and is shifted into the rd_data shadow LSB-first-in, giving MSB-first order.
  - After the 24th falling edge, go to HOLD.
- HOLD: CS_HOLD cycles, then n_cs=1, rd_data is updated from the shadow, frame_done=1 and rd_valid=1 for one cycle, then GAP.
- GAP: n_cs held high for CS_HIGH_MIN cycles, then IDLE.
- frame_ready is only high in IDLE. Frames presented while busy are not consumed, and upstream holds them.
- abort, in any non-IDLE state: in the next cycle n_cs=1, sck=0, mosi=0. Then go to GAP. No frame_done/rd_valid pulse. aborted is set only if the state was SETUP, SHIFT or HOLD. abort in IDLE is ignored, and frame_ready is forced low that cycle.
- An abort and a frame acceptance in the same cycle: the abort wins and no frame is accepted.

## Timing
- Accept-to-n_cs-low: 1 cycle; n_cs is registered.
- Frame length from the accept edge to the frame_done pulse is CS_SETUP + 48·HALF_PERIOD + CS_HOLD cycles. With the defaults that is 50.
- Minimum accept-to-accept spacing is that length plus CS_HIGH_MIN plus 1 (the IDLE cycle). With the defaults that is 53 cycles. The upstream sequencer's per-channel update delay must be at least this.
- All pin outputs are driven directly from flops, with no combinational path from frame_valid or abort to the pins.
- miso is used unsynchronized. Readback is only guaranteed for HALF_PERIOD ≥ 2, which gives at least one full clk of settle after sck rises.

## Structure
- Shared package ad5676_pkg holds:
  - command codes: CMD_WR_INPUT=4'h1, CMD_UPDATE=4'h2, CMD_WR_UPDATE=4'h3, CMD_READBACK=4'h9;
  - FRAME_BITS=24;
  - the state encoding.
- One natural sub-module, ad5676_sck_gen: the half-period down-counter producing sck_rise/sck_fall strobes. It is enabled only in SHIFT.

## Test plan
- Defaults, frame 0x3_2_8000: n_cs low 1 cycle after accept, mosi sequence 0011 0010 1000 0000 0000 0000, 24 sck pulses, frame_done exactly 50 cycles after accept.
- Back-to-back frame_valid held high with two frames: the second is accepted exactly 53 cycles after the first, and n_cs stays high ≥ 2 cycles between them.
- HALF_PERIOD=2, miso driven from a model returning 0xA5C3F0 on sck rising: rd_data=0xA5C3F0 with rd_valid coincident with frame_done.
- abort asserted at the 10th sck rising edge: n_cs=1 and sck=0 next cycle, no frame_done, aborted=1, next frame accepted after the GAP.
- resetn asserted mid-SHIFT: n_cs=1 with no clock edge, all outputs at reset values; after release, frame_ready=1 in the first cycle.
- abort and frame_valid in the same IDLE cycle: no frame accepted, aborted stays 0.
